neuron_mac: RTL
===============

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter NUM_WEIGHT, default 30: weights/inputs per neuron evaluation.
REQ-002 Parameter DATA_WIDTH, default 16: signed two's-complement width of inputs, weights, bias and output.
REQ-003 Parameter FRAC_BITS, default 12: fractional bits of all DATA_WIDTH values (1.0 = 4096).
REQ-004 Parameter ADDR_WIDTH, default $clog2(NUM_WEIGHT): weight address width.
REQ-005 Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_WIDTH  signed input activation.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- w_ren  out  1  weight memory read enable.
- w_radd  out  ADDR_WIDTH  weight memory read address.
- w_data  in  DATA_WIDTH  weight returned by memory one cycle after w_ren.
- bias  in  DATA_WIDTH  signed neuron bias, static during evaluation.
- out_data  out  DATA_WIDTH  activated neuron output.
- out_valid  out  1  one-cycle pulse, out_data updated.

Function
REQ-006 States IDLE, RUN, BIAS, OUT; sample accepted when in_valid && in_ready.
REQ-007 in_ready = 1 in IDLE, and in RUN while accepted count < NUM_WEIGHT; 0 otherwise.
REQ-008 w_ren is combinational = in_valid && in_ready; w_radd = accepted count (0 for first sample, NUM_WEIGHT-1 for last).
REQ-009 IDLE -> RUN on first accepted sample; accepted count increments per accepted sample.
REQ-010 Gaps in in_valid are permitted; pipeline stages advance only with their valid bits.
REQ-011 Stage 1: accepted in_data registered with valid bit at edge of acceptance cycle, aligned with w_data.
REQ-012 Stage 2: product in_d1*w_data, 2*DATA_WIDTH signed, registered with valid bit.
REQ-013 Stage 3: 2*DATA_WIDTH accumulator adds registered product, saturating to signed 2*DATA_WIDTH limits, no wrap.
REQ-014 RUN -> BIAS at the edge accumulating the NUM_WEIGHT-th product.
REQ-015 BIAS (one cycle): sum = sat(acc + (sign-extended bias << FRAC_BITS)); r = sum >>> FRAC_BITS; r saturated to DATA_WIDTH signed range; negative r -> 0 (ReLU); registered into out_data, out_valid set; state -> OUT.
REQ-016 OUT (one cycle): out_valid = 1; accumulator, count and pipeline valid bits cleared; state -> IDLE.
REQ-017 Latency: last sample accepted in cycle t -> out_valid high in cycle t+4 only; in_ready low in t+1..t+4, high again t+5.
REQ-018 out_data holds its value until the next evaluation's BIAS edge.
REQ-019 Samples presented while in_ready = 0 are ignored; w_ren stays 0 for them.

Reset
REQ-020 rst_n low asynchronously forces state IDLE, count 0, accumulator 0, all pipeline valid bits 0, out_data 0, out_valid 0.
REQ-021 Reset during any state aborts evaluation; no out_valid issued for the partial evaluation; first cycle after release in_ready = 1, w_ren follows in_valid.

Verification
REQ-022 Reset mid-RUN after 10 samples -> outputs 0, in_ready 1; fresh 30-sample run gives correct result, w_radd restarts at 0.
REQ-023 in_data = 4096 for sample 0 only, 0 otherwise; mem[0] = 4096; bias 0 -> out_data 4096, out_valid exactly once, 4 cycles after sample 29.
REQ-024 All inputs 4096, all weights 4096, bias 0 -> sum 30.0 -> out_data 32767 (saturated).
REQ-025 All inputs 4096, all weights -4096, bias 0 -> sum -30.0 -> out_data 0 (ReLU).
REQ-026 All inputs 0, bias 2048 -> out_data 2048.
REQ-027 in_valid random gaps, then held high 5 cycles past sample 29 -> w_radd sequence 0..29, no w_ren for extra samples, result identical to gap-free run.

Source files
------------

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
//
// Evaluates one neuron: NUM_WEIGHT multiply-accumulates of a streamed input
// activation against weights fetched from an external synchronous memory. A
// bias is then added, the result is rescaled and saturated, and a ReLU is
// applied. All values are signed fixed point with FRAC_BITS fractional bits.
//
// Pipeline: accept -> stage 1 (input register, aligned with returning weight)
//           -> stage 2 (product register) -> stage 3 (saturating accumulator)
//           -> BIAS (bias add, rescale, clamp, ReLU) -> OUT (clear and re-arm).
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    signed input activation
//   in_valid   in_data valid this cycle
//   in_ready   block accepts in_data this cycle
//   w_ren      weight memory read enable (combinational, = accepted sample)
//   w_radd     weight memory read address (= index of the accepted sample)
//   w_data     weight returned by memory one cycle after w_ren
//   bias       signed neuron bias, held static during an evaluation
//   out_data   activated neuron output, held until the next evaluation
//   out_valid  one-cycle pulse when out_data has been updated
// -----------------------------------------------------------------------------
module neuron_mac #(
  parameter int NUM_WEIGHT = 30,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         w_ren,
  output logic        [ADDR_WIDTH-1:0] w_radd,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid
);

  // Counters must be able to hold NUM_WEIGHT itself, not just NUM_WEIGHT-1.
  localparam int CNT_W = $clog2(NUM_WEIGHT + 1);
  localparam int ACC_W = 2 * DATA_WIDTH;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Largest positive DATA_WIDTH value, sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] OUT_MAX_EXT =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_BIAS = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]             cnt_reg;      // samples accepted
  logic [CNT_W-1:0]             acc_cnt_reg;  // products accumulated
  logic signed [DATA_WIDTH-1:0] in_d1_reg;
  logic                         v1_reg;
  logic signed [ACC_W-1:0]      prod_reg;
  logic                         v2_reg;
  logic signed [ACC_W-1:0]      acc_reg;

  logic                         accept;
  logic                         last_acc;
  logic signed [ACC_W-1:0]      prod_next;
  logic signed [ACC_W-1:0]      bias_ext;
  logic signed [ACC_W-1:0]      sum_biased;
  logic signed [ACC_W-1:0]      r_shift;
  logic signed [DATA_WIDTH-1:0] act_next;

  // Signed add that clamps to the accumulator range instead of wrapping.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      return s[ACC_W-1:0];
  endfunction

  assign accept   = in_valid && in_ready;
  // The product entering the accumulator this edge is the final one.
  assign last_acc = v2_reg && (acc_cnt_reg == CNT_W'(NUM_WEIGHT - 1));

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // ------------------------------------------------------------ FSM next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept)   state_next = S_RUN;
      S_RUN:   if (last_acc) state_next = S_BIAS;
      S_BIAS:                state_next = S_OUT;
      S_OUT:                 state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------- FSM outputs
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      S_IDLE:  in_ready = 1'b1;
      S_RUN:   in_ready = (cnt_reg < CNT_W'(NUM_WEIGHT));
      default: in_ready = 1'b0;
    endcase
    w_ren  = in_valid && in_ready;
    w_radd = ADDR_WIDTH'(cnt_reg);
  end

  // ----------------------------------------------------- output stage datapath
  always_comb begin
    prod_next  = in_d1_reg * w_data;
    bias_ext   = ACC_W'(bias) <<< FRAC_BITS;
    sum_biased = sat_add(acc_reg, bias_ext);
    r_shift    = sum_biased >>> FRAC_BITS;
    // ReLU first: any negative value (including below the output range) is 0.
    if (r_shift[ACC_W-1])
      act_next = '0;
    else if (r_shift > OUT_MAX_EXT)
      act_next = OUT_MAX;
    else
      act_next = r_shift[DATA_WIDTH-1:0];
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      acc_cnt_reg <= '0;
      in_d1_reg   <= '0;
      v1_reg      <= 1'b0;
      prod_reg    <= '0;
      v2_reg      <= 1'b0;
      acc_reg     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= (state_reg == S_BIAS);
      if (state_reg == S_BIAS)
        out_data <= act_next;

      if (state_reg == S_OUT) begin
        cnt_reg     <= '0;
        acc_cnt_reg <= '0;
        v1_reg      <= 1'b0;
        v2_reg      <= 1'b0;
        acc_reg     <= '0;
      end else begin
        // Stage 1: input lands in the same cycle as its weight from memory.
        v1_reg <= accept;
        if (accept) begin
          in_d1_reg <= in_data;
          cnt_reg   <= cnt_reg + 1'b1;
        end
        // Stage 2: product register.
        v2_reg <= v1_reg;
        if (v1_reg)
          prod_reg <= prod_next;
        // Stage 3: saturating accumulate.
        if (v2_reg) begin
          acc_reg     <= sat_add(acc_reg, prod_reg);
          acc_cnt_reg <= acc_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule
